// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - boot-time byte-stream loader for the instruction memory
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle pulse that opens a load session (ignored while busy)
//   byte_valid/data incoming byte stream; byte_ready is the registered accept
//   mem_we/addr/wdata  single-cycle word write into the instruction memory
//   busy, cpu_hold  session in progress (cpu_hold mirrors busy)
//   done, err       sticky session outcome, mutually exclusive
//   words_loaded    words written in the current session

module instr_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [1:0]          idx_q, idx_d;
  logic                byte_ready_q, byte_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                accept;
  logic [15:0]         hdr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      words_q      <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      words_q      <= words_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    err_d       = err_q;
    words_d     = words_q;
    accept      = byte_valid & byte_ready_q;
    hdr         = {count_q[15:8], byte_data};

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = HDR_HI;
          done_d     = 1'b0;
          err_d      = 1'b0;
          words_d    = '0;
          mem_addr_d = '0;
        end
      end
      HDR_HI: begin
        if (accept) begin
          count_d[15:8] = byte_data;
          state_d       = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          count_d = hdr;
          if (hdr == 16'd0 || {1'b0, hdr} > DEPTH_L) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
      end
      DATA: begin
        if (accept) begin
          // Big-endian packing: the first byte ends up in [31:24].
          mem_wdata_d = {mem_wdata_q[23:0], byte_data};
          idx_d       = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        words_d    = words_q + (ADDR_W+1)'(1);
        // Wraps to 0 after the DEPTH-th word, by which point we are in DONE.
        mem_addr_d = mem_addr_q + ADDR_W'(1);
        if (16'(words_q) + 16'd1 == count_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered strobes are decoded from the next state so they line up
    // with the state they describe.
    byte_ready_d = (state_d == HDR_HI) || (state_d == HDR_LO) || (state_d == DATA);
    mem_we_d     = (state_d == WRITE);
    busy_d       = byte_ready_d || mem_we_d;
  end

  assign byte_ready   = byte_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = busy_q;
  assign cpu_hold     = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized self-checking bench for instr_loader

module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_we, busy, cpu_hold, done, err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] words_loaded;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  dbytes [4096];
  logic [41:0] wq[$];
  logic [41:0] img0[$];
  logic        prev_we = 1'b0;

  instr_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Write monitor: records every write and checks its framing.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      check_eq("we_single_cycle", 64'(prev_we), 64'd0);
      check_eq("ready_low_in_write", 64'(byte_ready), 64'd0);
      check_eq("hold_in_write", 64'(cpu_hold), 64'd1);
      wq.push_back({mem_addr, mem_wdata});
    end
    prev_we = mem_we;
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"},
             64'({byte_ready, mem_we, busy, cpu_hold, done, err}), 64'd0);
    check_eq({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check_eq({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    check_eq({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_start();
    pulse_start();
    wq.delete();
    check_eq("start_addr", 64'(mem_addr), 64'd0);
    check_eq("start_state", 64'({busy, cpu_hold, done, err, byte_ready}), 64'b11001);
    check_eq("start_words", 64'(words_loaded), 64'd0);
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap;
    int tmo;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    tmo = 0;
    while (!byte_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 50) check_eq("ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic fill_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) dbytes[i] = 8'($urandom);
  endtask

  task automatic load(input int cnt, input int maxgap, input bit poke);
    logic [15:0] c;
    c = 16'(cnt);
    do_start();
    send_byte(c[15:8], maxgap);
    if (poke) pulse_start();
    send_byte(c[7:0], maxgap);
    if (cnt >= 1 && cnt <= 1024) begin
      for (int i = 0; i < cnt * 4; i++) begin
        send_byte(dbytes[i], maxgap);
        if (poke && i == 0) pulse_start();
      end
    end
  endtask

  // Reference: a legal count writes words 0..cnt-1 packed big-endian from
  // the byte array, anything else raises err with no writes.
  task automatic expect_session(input string tag, input int cnt);
    bit ok;
    int tmo;
    logic [41:0] exp;
    ok = (cnt >= 1 && cnt <= 1024);
    tmo = 0;
    while (!(done || err) && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    check_eq({tag, "_finish"}, 64'(tmo < 20), 64'd1);
    check_eq({tag, "_done"}, 64'(done), 64'(ok));
    check_eq({tag, "_err"}, 64'(err), 64'(!ok));
    check_eq({tag, "_idle"}, 64'({busy, cpu_hold, byte_ready}), 64'd0);
    check_eq({tag, "_words"}, 64'(words_loaded), ok ? 64'(cnt) : 64'd0);
    check_eq({tag, "_nwrites"}, 64'(wq.size()), ok ? 64'(cnt) : 64'd0);
    if (ok && wq.size() == cnt) begin
      for (int i = 0; i < cnt; i++) begin
        exp = {10'(i), dbytes[4*i], dbytes[4*i+1], dbytes[4*i+2], dbytes[4*i+3]};
        check_eq({tag, "_write"}, 64'(wq[i]), 64'(exp));
      end
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Two words, gapless, fixed pattern.
    dbytes[0] = 8'h12; dbytes[1] = 8'h34; dbytes[2] = 8'h56; dbytes[3] = 8'h78;
    dbytes[4] = 8'h9A; dbytes[5] = 8'hBC; dbytes[6] = 8'hDE; dbytes[7] = 8'hF0;
    load(2, 0, 1'b0);
    expect_session("two_words", 2);
    check_eq("word0_lit", 64'(wq.size() > 0 ? wq[0] : 42'd0), 64'({10'd0, 32'h12345678}));

    // Zero count, then a good one-word load clears err.
    load(0, 0, 1'b0);
    expect_session("count_zero", 0);
    fill_random(4);
    load(1, 2, 1'b0);
    expect_session("after_err", 1);

    // Count just above and exactly at the depth.
    load(1025, 0, 1'b0);
    expect_session("count_1025", 1025);
    fill_random(4096);
    load(1024, 0, 1'b0);
    expect_session("count_1024", 1024);
    check_eq("last_addr", 64'(wq.size() > 0 ? wq[wq.size()-1][41:32] : 10'd0), 64'h3FF);

    // Same three words gapless and with random gaps must give the same image.
    fill_random(12);
    load(3, 0, 1'b0);
    expect_session("gapless", 3);
    img0 = wq;
    load(3, 5, 1'b0);
    expect_session("gapped", 3);
    check_eq("gap_image", 64'(wq == img0), 64'd1);

    // Reset after the 6th data byte of a 4-word load.
    fill_random(16);
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    for (int i = 0; i < 6; i++) send_byte(dbytes[i], 0);
    check_eq("pre_reset_writes", 64'(wq.size()), 64'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("post_reset_writes", 64'(wq.size()), 64'd1);
    check_all_zero("post_reset");
    load(4, 1, 1'b0);
    expect_session("after_reset", 4);

    // start pulsed in HDR_LO and DATA is ignored.
    fill_random(20);
    load(5, 1, 1'b1);
    expect_session("start_ignored", 5);

    // start in DONE opens a fresh session at address 0 (checked by do_start).
    load(2, 3, 1'b0);
    expect_session("restart_from_done", 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time writer for the instruction memory.
- Accepts a byte stream with a valid/ready handshake: a 2-byte word-count header, then instruction words, most significant byte first.
- Packs each group of four bytes into a 32-bit word and drives a single-cycle write into the instruction memory's write port, at word addresses 0, 1, 2 and so on.
- Holds the CPU off (cpu_hold) while loading, then reports done or error.

Parameters:
- ADDR_W, 10, word-address width of the instruction memory.
- DEPTH, 1024, maximum number of words; a header count above this is an error.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load session.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  incoming stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write enable, high for one cycle per word.
- mem_addr  output  ADDR_W  word address for the write.
- mem_wdata  output  32  word to write.
- busy  output  1  session in progress.
- cpu_hold  output  1  keeps the CPU stalled/reset; equals busy.
- done  output  1  sticky; all words written.
- err  output  1  sticky; header count is invalid.
- words_loaded  output  ADDR_W+1  number of words written so far in this session.

Behaviour:
- Reset:
  - rst=1 asynchronously clears every output: mem_we, mem_addr, mem_wdata, byte_ready, busy, cpu_hold, done, err and words_loaded all go to 0.
  - The FSM returns to IDLE.
  - Reset mid-session abandons the load. Memory contents already written stay as written.
- Handshake:
  - A byte is accepted on a rising edge where byte_valid=1 and byte_ready=1.
  - byte_ready is registered. It is 1 only in HDR_HI, HDR_LO and DATA.
  - Gaps in byte_valid of any length are allowed.
  - byte_ready does not depend combinationally on byte_valid.
- FSM states:
  - IDLE: start=1 -> HDR_HI. On this transition, clear done, err and words_loaded, set busy=1, and set mem_addr=0.
  - HDR_HI: an accepted byte becomes count[15:8] -> HDR_LO.
  - HDR_LO: an accepted byte becomes count[7:0]. If the count is 0 or greater than DEPTH, go to ERR; otherwise go to DATA with the byte index set to 0.
  - DATA:
    - Accepted bytes shift into mem_wdata. Byte 0 goes to bits [31:24] and byte 3 to bits [7:0], which is big-endian.
    - After the 4th byte, go to WRITE.
  - WRITE:
    - Exactly one cycle with mem_we=1, byte_ready=0; mem_addr and mem_wdata are stable.
    - On exit, words_loaded increments and mem_addr increments.
    - If the new words_loaded equals count, go to DONE; otherwise go back to DATA.
  - DONE: done=1, busy=0, cpu_hold=0. start=1 begins a new session, with the same transition as from IDLE.
  - ERR: err=1, busy=0, cpu_hold=0, no writes. start=1 begins a new session.
- Latency:
  - The WRITE cycle immediately follows the edge that accepted the 4th byte.
  - The minimum time per word is 5 cycles: 4 accept cycles plus 1 write cycle.
- Boundaries:
  - start while busy is ignored.
  - A count equal to DEPTH is legal. The last write goes to address DEPTH-1.
  - mem_addr is never incremented past DEPTH-1 while in DATA.
  - When count=DEPTH, mem_addr wraps to 0 after the final write. This is harmless because the FSM is then in DONE.
  - Bytes presented in IDLE, DONE or ERR are not accepted (byte_ready=0).
  - done and err are never both 1.

Test Plan:
- Header 0x00,0x02; bytes 12 34 56 78 9A BC DE F0, byte_valid held high -> write addr0=0x12345678, then addr1=0x9ABCDEF0; each mem_we pulse is 1 cycle; done=1, words_loaded=2, cpu_hold falls with done; byte_ready is 0 during the write cycles.
- Header 0x00,0x00 -> err=1, done=0, no mem_we pulse, busy=0; then start plus a valid 1-word load -> err clears and done=1.
- Header 0x04,0x01 (1025) -> err=1; header 0x04,0x00 (1024) with 1024 words -> last write at addr 0x3FF, words_loaded=1024, done=1.
- Random gaps of 0–5 cycles in byte_valid while loading 3 words -> memory image is identical to the gapless run; no byte is duplicated or dropped.
- rst pulsed after the 6th data byte of a 4-word load -> all outputs 0 immediately, no further mem_we; a new start plus a full load succeeds.
- start pulsed in HDR_LO and in DATA -> ignored, and the load completes normally; start in DONE -> a new session begins with mem_addr=0.
